// File: rtl/puf_challenge_sequencer.sv
// puf_challenge_sequencer
// Drives an arbiter PUF core. Each challenge is evaluated NVOTE times, and the
// response bits are majority-voted and packed into a word. The word is then
// returned over a valid/ready port.
//
// Handshake: resp_valid_o is high in DONE and stays high, with resp_data_o
// stable, until a cycle where resp_ready_i is also high. That cycle is the
// transfer. resp_valid_o and busy_o are low on the following cycle.
module puf_challenge_sequencer #(
    parameter int CHAL_W     = 8,
    parameter int RESP_BITS  = 32,
    parameter int NVOTE      = 3,
    parameter int SETTLE_CYC = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [CHAL_W-1:0]    seed_i,
    output logic                 busy_o,
    output logic                 puf_trigger_o,
    output logic [CHAL_W-1:0]    puf_challenge_o,
    input  logic                 puf_response_i,
    output logic [RESP_BITS-1:0] resp_data_o,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [7:0]           unstable_cnt_o
);

    localparam int ONES_W = $clog2(NVOTE + 1);
    localparam int VOTE_W = (NVOTE > 1) ? $clog2(NVOTE) : 1;
    localparam int BIT_W  = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int PH_W   = $clog2(SETTLE_CYC + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        FIRE = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [PH_W-1:0]       phase_q, phase_d;
    logic [VOTE_W-1:0]     vote_q, vote_d;
    logic [ONES_W-1:0]     ones_q, ones_d;
    logic [BIT_W-1:0]      bit_idx_q, bit_idx_d;
    logic [CHAL_W-1:0]     chal_q, chal_d;
    logic [RESP_BITS-1:0]  data_q, data_d;
    logic [7:0]            unstable_q, unstable_d;
    logic                  trig_q, trig_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  sync1_q, sync2_q;

    logic [ONES_W-1:0]     ones_final;
    logic                  voted_bit;
    logic                  unanimous;

    // Fibonacci LFSR step. The taps are 7,5,4,3, so a nonzero state never reaches 0.
    function automatic logic [CHAL_W-1:0] lfsr_next(input logic [CHAL_W-1:0] c);
        return {c[CHAL_W-2:0], c[7] ^ c[5] ^ c[4] ^ c[3]};
    endfunction

    // Vote arithmetic for the evaluation that is finishing in this FIRE cycle.
    always_comb begin
        ones_final = ones_q + ONES_W'(sync2_q);
        voted_bit  = (ones_final > ONES_W'(NVOTE / 2));
        unanimous  = (ones_final == '0) || (ones_final == ONES_W'(NVOTE));
    end

    // Next-state and next-output logic. All outputs are taken directly from flops.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        vote_d     = vote_q;
        ones_d     = ones_q;
        bit_idx_d  = bit_idx_q;
        chal_d     = chal_q;
        data_d     = data_q;
        unstable_d = unstable_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = ARM;
                    phase_d    = '0;
                    vote_d     = '0;
                    ones_d     = '0;
                    bit_idx_d  = '0;
                    data_d     = '0;
                    unstable_d = '0;
                    // A zero seed would lock up the LFSR, so it is replaced by 1.
                    chal_d     = (seed_i == '0) ? CHAL_W'(1) : seed_i;
                end
            end
            ARM: begin
                if (phase_q == PH_W'(SETTLE_CYC - 1)) begin
                    phase_d = '0;
                    state_d = FIRE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            FIRE: begin
                if (phase_q == PH_W'(SETTLE_CYC + 1)) begin
                    phase_d = '0;
                    state_d = ARM;
                    if (vote_q == VOTE_W'(NVOTE - 1)) begin
                        vote_d            = '0;
                        ones_d            = '0;
                        data_d[bit_idx_q] = voted_bit;
                        if (!unanimous && (unstable_q != 8'hff))
                            unstable_d = unstable_q + 8'd1;
                        chal_d = lfsr_next(chal_q);
                        if (bit_idx_q == BIT_W'(RESP_BITS - 1))
                            state_d = DONE;
                        else
                            bit_idx_d = bit_idx_q + 1'b1;
                    end else begin
                        vote_d = vote_q + 1'b1;
                        ones_d = ones_final;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            DONE: begin
                if (resp_ready_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        trig_d  = (state_d == FIRE);
        valid_d = (state_d == DONE);
        busy_d  = (state_d != IDLE);
    end

    // State, datapath and output registers, plus the response synchronizer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            vote_q     <= '0;
            ones_q     <= '0;
            bit_idx_q  <= '0;
            chal_q     <= '0;
            data_q     <= '0;
            unstable_q <= '0;
            trig_q     <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            vote_q     <= vote_d;
            ones_q     <= ones_d;
            bit_idx_q  <= bit_idx_d;
            chal_q     <= chal_d;
            data_q     <= data_d;
            unstable_q <= unstable_d;
            trig_q     <= trig_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            sync1_q    <= puf_response_i;
            sync2_q    <= sync1_q;
        end
    end

    // Output ports are driven directly by their registers.
    always_comb begin
        busy_o          = busy_q;
        puf_trigger_o   = trig_q;
        puf_challenge_o = chal_q;
        resp_data_o     = data_q;
        resp_valid_o    = valid_q;
        unstable_cnt_o  = unstable_q;
    end

endmodule
